// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parameterised accumulator CPU core with on-chip program/data RAM
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset (wins over load_mode)
//   load_mode  in   1 = core held in LOAD, RAM writable from program port
//   prog_we    in   program-port write strobe (only while load_mode=1)
//   prog_addr  in   [ADDR_W] program-port write address
//   prog_data  in   [DATA_W] program-port write data
//   out_data   out  [DATA_W] output register, written by OUT
//   out_valid  out  one-cycle pulse after out_data is updated
//   halted     out  high while in HALT
//   carry      out  ALU carry flag (carry=1 on SUB means no borrow)
//   zero       out  ALU zero flag
//   pc         out  [ADDR_W] program counter
module cpu_core_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_mode,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic              carry,
   output logic              zero,
   output logic [ADDR_W-1:0] pc
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_LOAD,
      S_T0,
      S_T1,
      S_E1,
      S_E2,
      S_E3,
      S_HALT
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [DATA_W-1:0] r_ram [DEPTH];
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_mar;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   // Only the decoded fields of the instruction word are kept; the bits in
   // between opcode and operand carry no meaning.
   logic [3:0]        r_ir_op;
   logic [ADDR_W-1:0] r_ir_arg;
   logic [DATA_W-1:0] r_out;
   logic              r_out_valid;
   logic              r_carry;
   logic              r_zero;

   logic [DATA_W-1:0] w_ram_rd;
   logic              w_is_mem;
   logic              w_is_alu;
   logic              w_is_sub;
   logic              w_jump_take;
   logic [DATA_W-1:0] w_b_operand;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_arg_zext;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [DATA_W-1:0] w_ram_wdata;

   // Asynchronous read port always follows MAR.
   assign w_ram_rd    = r_ram[r_mar];

   assign w_is_mem    = (r_ir_op == OP_LDA) || (r_ir_op == OP_ADD) ||
                        (r_ir_op == OP_SUB) || (r_ir_op == OP_STA);
   assign w_is_alu    = (r_ir_op == OP_ADD) || (r_ir_op == OP_SUB);
   assign w_is_sub    = (r_ir_op == OP_SUB);
   assign w_jump_take = (r_ir_op == OP_JMP) ||
                        ((r_ir_op == OP_JC) && r_carry) ||
                        ((r_ir_op == OP_JZ) && r_zero);

   // SUB is A + ~B + 1, so the carry-out doubles as "no borrow".
   assign w_b_operand = w_is_sub ? ~r_b : r_b;
   assign w_sum       = {1'b0, r_a} + {1'b0, w_b_operand} + {{DATA_W{1'b0}}, w_is_sub};
   assign w_arg_zext  = {{(DATA_W-ADDR_W){1'b0}}, r_ir_arg};

   // Next-state logic; load_mode pre-empts every state, rst is applied in
   // the state register so it outranks load_mode.
   always_comb begin
      w_next_state = r_state;
      if (load_mode) begin
         w_next_state = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD: w_next_state = S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1:   w_next_state = S_E1;
            S_E1: begin
               if (r_ir_op == OP_HLT)  w_next_state = S_HALT;
               else if (w_is_mem)      w_next_state = S_E2;
               else                    w_next_state = S_T0;
            end
            S_E2:   w_next_state = w_is_alu ? S_E3 : S_T0;
            S_E3:   w_next_state = S_T0;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_T0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_T0;
      else     r_state <= w_next_state;
   end

   // Single RAM write port shared by the program port and STA; load_mode
   // selects the source so the two can never collide, and rst blocks both.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_waddr = r_mar;
      w_ram_wdata = r_a;
      if (!rst) begin
         if (load_mode) begin
            w_ram_we    = prog_we;
            w_ram_waddr = prog_addr;
            w_ram_wdata = prog_data;
         end else begin
            w_ram_we    = (r_state == S_E2) && (r_ir_op == OP_STA);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= '0;
         r_mar       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_ir_op     <= '0;
         r_ir_arg    <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
      end else if (load_mode) begin
         // Core frozen: architectural state kept, execution restarts at 0.
         r_pc        <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_T0: r_mar <= r_pc;
            S_T1: begin
               r_ir_op  <= w_ram_rd[DATA_W-1 -: 4];
               r_ir_arg <= w_ram_rd[ADDR_W-1:0];
               r_pc     <= r_pc + ADDR_W'(1);
            end
            S_E1: begin
               case (r_ir_op)
                  OP_NOP: ;
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= r_ir_arg;
                  OP_LDI: r_a <= w_arg_zext;
                  OP_JMP, OP_JC, OP_JZ: begin
                     if (w_jump_take) r_pc <= r_ir_arg;
                  end
                  OP_OUT: begin
                     r_out       <= r_a;
                     r_out_valid <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_E2: begin
               if (r_ir_op == OP_LDA) r_a <= w_ram_rd;
               else if (w_is_alu)     r_b <= w_ram_rd;
            end
            S_E3: begin
               r_a     <= w_sum[DATA_W-1:0];
               r_carry <= w_sum[DATA_W];
               r_zero  <= (w_sum[DATA_W-1:0] == '0);
            end
            default: ;
         endcase
      end
   end

   assign out_data  = r_out;
   assign out_valid = r_out_valid;
   assign halted    = (r_state == S_HALT);
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign pc        = r_pc;

endmodule

// File: tb/tb_cpu_core_param.sv
// tb/tb_cpu_core_param.sv - scoreboard testbench for cpu_core_param
module tb_cpu_core_param;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_mode = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [DW-1:0] prog_data = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          halted;
   logic          carry;
   logic          zero;
   logic [AW-1:0] pc;

   cpu_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_mode (load_mode),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .carry     (carry),
      .zero      (zero),
      .pc        (pc)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_pass = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] img [16];
   logic          prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every out_valid pulse pops one expected value.
   always @(negedge clk) begin
      if (out_valid) begin
         check("out_valid_single_cycle", {31'd0, prev_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL out_unexpected: got %0h expected no output", out_data);
         end else begin
            check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
      prev_valid = out_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_img();
      foreach (img[i]) img[i] = '0;
   endtask

   task automatic reset_into_load();
      rst = 1'b1;
      load_mode = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic write_words(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         prog_we   = 1'b1;
         prog_addr = AW'(i);
         prog_data = img[i];
         tick();
      end
      prog_we = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, output int cycles);
      load_mode = 1'b0;
      cycles = 0;
      while (!halted && cycles < budget) begin
         tick();
         cycles++;
      end
      check("halted", {31'd0, halted}, 32'd1);
   endtask

   initial begin
      int cyc;
      int n;
      bit seen;
      logic [AW-1:0] last;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_pc", {28'd0, pc}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_carry", {31'd0, carry}, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);

      // 28 + 14 = 42, LDA/ADD/OUT/HLT = 15 cycles after LOAD->T0
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
      img[14] = 8'd28; img[15] = 8'd14;
      reset_into_load();
      write_words(0, 16);
      exp_q.push_back(8'd42);
      run_to_halt(100, cyc);
      check("demo_cycles", cyc, 32'd16);
      check("demo_carry", {31'd0, carry}, 32'd0);
      check("demo_zero", {31'd0, zero}, 32'd0);
      check("demo_out_data", {24'd0, out_data}, 32'd42);
      check("demo_queue_empty", exp_q.size(), 32'd0);

      // LDI 5; STA 9; SUB 9; OUT; LDA 9; OUT; HLT  (RAM[9] was 7)
      clear_img();
      img[0] = 8'h55; img[1] = 8'h49; img[2] = 8'h39; img[3] = 8'hE0;
      img[4] = 8'h19; img[5] = 8'hE0; img[6] = 8'hF0; img[9] = 8'h07;
      reset_into_load();
      write_words(0, 16);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h05);
      run_to_halt(200, cyc);
      check("sub_cycles", cyc, 32'd26);
      check("sub_zero", {31'd0, zero}, 32'd1);
      check("sub_carry", {31'd0, carry}, 32'd1);
      check("sub_queue_empty", exp_q.size(), 32'd0);

      // 0xFF + 1 -> 0 with carry; JC 12 taken; ADD 14 -> 0xFF; JZ not taken; HLT at 14
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'h7C;
      for (int i = 4; i < 12; i++) img[i] = 8'hF0;
      img[12] = 8'h2E; img[13] = 8'h80; img[14] = 8'hFF; img[15] = 8'h01;
      reset_into_load();
      write_words(0, 16);
      exp_q.push_back(8'h00);
      run_to_halt(200, cyc);
      check("jump_cycles", cyc, 32'd27);
      check("jump_pc", {28'd0, pc}, 32'd15);
      check("jump_carry", {31'd0, carry}, 32'd0);
      check("jump_zero", {31'd0, zero}, 32'd0);
      check("jump_queue_empty", exp_q.size(), 32'd0);

      // 16 NOPs: PC wraps 15 -> 0 every 48 cycles
      clear_img();
      reset_into_load();
      write_words(0, 16);
      load_mode = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         n = 0;
         seen = 1'b0;
         last = pc;
         while (!seen && n < 200) begin
            tick();
            n++;
            if (last == 4'd15 && pc == 4'd0) seen = 1'b1;
            last = pc;
         end
         check("nop_wrap_seen", {31'd0, seen}, 32'd1);
      end
      check("nop_period", n, 32'd48);

      // load_mode mid-run; ignored prog_we; restart at 0 with A kept
      clear_img();
      img[0] = 8'h2F; img[1] = 8'hE0; img[2] = 8'h60; img[15] = 8'h01;
      reset_into_load();
      write_words(0, 16);
      exp_q.push_back(8'h01);
      load_mode = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 50) begin
         tick();
         n++;
         if (out_valid) seen = 1'b1;
      end
      check("loop_out_seen", {31'd0, seen}, 32'd1);
      load_mode = 1'b1;
      tick();
      img[2] = 8'hF0;
      write_words(2, 1);
      load_mode = 1'b0;
      tick();
      prog_we   = 1'b1;
      prog_addr = 4'd15;
      prog_data = 8'h50;
      exp_q.push_back(8'h02);
      tick();
      prog_we = 1'b0;
      run_to_halt(100, cyc);
      check("restart_pc", {28'd0, pc}, 32'd3);
      check("restart_out_data", {24'd0, out_data}, 32'd2);
      check("restart_queue_empty", exp_q.size(), 32'd0);

      // rst during E2 of STA 10: RAM[10] must keep 0x66
      clear_img();
      img[0] = 8'h3B; img[1] = 8'h4A; img[2] = 8'hF0; img[10] = 8'h66;
      reset_into_load();
      write_words(0, 16);
      load_mode = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      check("abort_pc", {28'd0, pc}, 32'd0);
      check("abort_halted", {31'd0, halted}, 32'd0);
      check("abort_carry", {31'd0, carry}, 32'd0);
      check("abort_zero", {31'd0, zero}, 32'd0);
      check("abort_out_data", {24'd0, out_data}, 32'd0);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      load_mode = 1'b1;
      tick();
      img[0] = 8'h1A; img[1] = 8'hE0; img[2] = 8'hF0;
      write_words(0, 3);
      exp_q.push_back(8'h66);
      run_to_halt(100, cyc);
      check("abort_queue_empty", exp_q.size(), 32'd0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
